// File: rtl/decode_unit.sv
// decode_unit: RV32I decode stage with register file, early branch/jump
// resolution and a registered valid/ready output stage toward EXE.
//
// Parameters: XLEN (datapath width), NUM_REGS (16 or 32),
//             SP_INIT / GP_INIT (reset values of x2 / x3).
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   in_valid/in_ready/in_instr      instruction handshake from fetch
//   in_pc, in_pc_inc                PC of the instruction and PC+4
//   flush_exe                       squash the instruction presented this cycle
//   fwd_rs1, fwd_rs2, exe_alu_result  EXE forwarding for branch operands
//   wb_wr_en, wb_rd, wb_data        register write-back
//   pc_src, branch_target           combinational fetch redirect
//   rs1_d, rs2_d                    source indices for the hazard unit
//   out_valid/out_ready             handshake toward EXE
//   out_rs1..out_ctrl               registered payload
// Configuration macro: DECODE_WB_BYPASS_EN (write-through read bypass).

module decode_unit #(
   parameter int unsigned     XLEN     = 32,
   parameter int unsigned     NUM_REGS = 32,
   parameter logic [XLEN-1:0] SP_INIT  = XLEN'(32'h300),
   parameter logic [XLEN-1:0] GP_INIT  = XLEN'(32'h300)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   input  logic [XLEN-1:0] in_pc_inc,
   input  logic            flush_exe,
   input  logic            fwd_rs1,
   input  logic            fwd_rs2,
   input  logic [XLEN-1:0] exe_alu_result,
   input  logic            wb_wr_en,
   input  logic [4:0]      wb_rd,
   input  logic [XLEN-1:0] wb_data,
   output logic            pc_src,
   output logic [XLEN-1:0] branch_target,
   output logic [4:0]      rs1_d,
   output logic [4:0]      rs2_d,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_rs1,
   output logic [XLEN-1:0] out_rs2,
   output logic [XLEN-1:0] out_imm,
   output logic [XLEN-1:0] out_pc,
   output logic [XLEN-1:0] out_pc_inc,
   output logic [4:0]      out_a1,
   output logic [4:0]      out_a2,
   output logic [4:0]      out_rd,
   output logic [11:0]     out_ctrl
);

   localparam int unsigned AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [2:0] IMM_I  = 3'd0;
   localparam logic [2:0] IMM_S  = 3'd1;
   localparam logic [2:0] IMM_B  = 3'd2;
   localparam logic [2:0] IMM_J  = 3'd3;
   localparam logic [2:0] IMM_U  = 3'd4;
   localparam logic [2:0] IMM_SH = 3'd5;

   // ALU codes beyond {funct7[5], funct3}: pass immediate, PC + immediate
   localparam logic [3:0] ALU_ADD   = 4'b0000;
   localparam logic [3:0] ALU_SUB   = 4'b1000;
   localparam logic [3:0] ALU_PASSB = 4'b1010;
   localparam logic [3:0] ALU_PCIMM = 4'b1011;

   // Instruction fields
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic [4:0] rs1_idx;
   logic [4:0] rs2_idx;
   logic [4:0] rd_idx;

   assign opcode  = in_instr[6:0];
   assign rd_idx  = in_instr[11:7];
   assign funct3  = in_instr[14:12];
   assign rs1_idx = in_instr[19:15];
   assign rs2_idx = in_instr[24:20];
   assign funct7  = in_instr[31:25];
   assign rs1_d   = rs1_idx;
   assign rs2_d   = rs2_idx;

   // Control decoder
   logic       reg_write;
   logic [1:0] result_src;
   logic       mem_store;
   logic       mem_load;
   logic [3:0] alu_control;
   logic       alu_src;
   logic       branch;
   logic       jal;
   logic       jalr;
   logic [2:0] imm_src;
   logic       op_illegal;
   logic       use_rs1;
   logic       use_rs2;
   logic       use_rd;

   always_comb begin
      reg_write   = 1'b0;
      result_src  = 2'b00;
      mem_store   = 1'b0;
      mem_load    = 1'b0;
      alu_control = ALU_ADD;
      alu_src     = 1'b0;
      branch      = 1'b0;
      jal         = 1'b0;
      jalr        = 1'b0;
      imm_src     = IMM_I;
      op_illegal  = 1'b0;
      use_rs1     = 1'b0;
      use_rs2     = 1'b0;
      use_rd      = 1'b0;
      case (opcode)
         OP_R: begin
            reg_write   = 1'b1;
            alu_control = {funct7[5], funct3};
            use_rs1     = 1'b1;
            use_rs2     = 1'b1;
            use_rd      = 1'b1;
            op_illegal  = !((funct7 == 7'b0000000) ||
                            ((funct7 == 7'b0100000) &&
                             ((funct3 == 3'b000) || (funct3 == 3'b101))));
         end
         OP_IMM: begin
            reg_write = 1'b1;
            alu_src   = 1'b1;
            use_rs1   = 1'b1;
            use_rd    = 1'b1;
            if (funct3 == 3'b001) begin
               imm_src     = IMM_SH;
               alu_control = {1'b0, funct3};
               op_illegal  = (funct7 != 7'b0000000);
            end else if (funct3 == 3'b101) begin
               imm_src     = IMM_SH;
               alu_control = {funct7[5], funct3};
               op_illegal  = !((funct7 == 7'b0000000) || (funct7 == 7'b0100000));
            end else begin
               alu_control = {1'b0, funct3};
            end
         end
         OP_LOAD: begin
            reg_write  = 1'b1;
            result_src = 2'b01;
            mem_load   = 1'b1;
            alu_src    = 1'b1;
            use_rs1    = 1'b1;
            use_rd     = 1'b1;
            op_illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
         end
         OP_STORE: begin
            mem_store  = 1'b1;
            alu_src    = 1'b1;
            imm_src    = IMM_S;
            use_rs1    = 1'b1;
            use_rs2    = 1'b1;
            op_illegal = (funct3[2] == 1'b1) || (funct3 == 3'b011);
         end
         OP_BRANCH: begin
            branch      = 1'b1;
            imm_src     = IMM_B;
            alu_control = ALU_SUB;
            use_rs1     = 1'b1;
            use_rs2     = 1'b1;
            op_illegal  = (funct3 == 3'b010) || (funct3 == 3'b011);
         end
         OP_JAL: begin
            reg_write  = 1'b1;
            result_src = 2'b10;
            jal        = 1'b1;
            imm_src    = IMM_J;
            use_rd     = 1'b1;
         end
         OP_JALR: begin
            reg_write  = 1'b1;
            result_src = 2'b10;
            jalr       = 1'b1;
            alu_src    = 1'b1;
            use_rs1    = 1'b1;
            use_rd     = 1'b1;
            op_illegal = (funct3 != 3'b000);
         end
         OP_LUI: begin
            reg_write   = 1'b1;
            alu_src     = 1'b1;
            alu_control = ALU_PASSB;
            imm_src     = IMM_U;
            use_rd      = 1'b1;
         end
         OP_AUIPC: begin
            reg_write   = 1'b1;
            alu_src     = 1'b1;
            alu_control = ALU_PCIMM;
            imm_src     = IMM_U;
            use_rd      = 1'b1;
         end
         default: op_illegal = 1'b1;
      endcase
   end

   // Immediate generation: built at 32 bits, then extended to XLEN
   logic [31:0]     imm32;
   logic [XLEN-1:0] imm;

   always_comb begin
      imm32 = 32'd0;
      case (imm_src)
         IMM_I:  imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
         IMM_S:  imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
         IMM_B:  imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                          in_instr[30:25], in_instr[11:8], 1'b0};
         IMM_J:  imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                          in_instr[20], in_instr[30:21], 1'b0};
         IMM_U:  imm32 = {in_instr[31:12], 12'd0};
         IMM_SH: imm32 = {27'd0, in_instr[24:20]};
         default: imm32 = 32'd0;
      endcase
   end

   assign imm = (imm_src == IMM_SH) ? XLEN'(imm32) : XLEN'($signed(imm32));

   // Register file
   logic [XLEN-1:0] regs [NUM_REGS];
   logic            rs1_in_range;
   logic            rs2_in_range;
   logic            rd_in_range;
   logic            wb_hit;
   logic [XLEN-1:0] rs1_val;
   logic [XLEN-1:0] rs2_val;

   assign rs1_in_range = ({1'b0, rs1_idx} < 6'(NUM_REGS));
   assign rs2_in_range = ({1'b0, rs2_idx} < 6'(NUM_REGS));
   assign rd_in_range  = ({1'b0, rd_idx}  < 6'(NUM_REGS));
   assign wb_hit       = wb_wr_en && (wb_rd != 5'd0) && ({1'b0, wb_rd} < 6'(NUM_REGS));

   // Reset reloads the whole array; x0 is never written so it stays 0
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs[AW'(i)] <= (i == 2) ? SP_INIT : ((i == 3) ? GP_INIT : '0);
         end
      end else if (wb_hit) begin
         regs[AW'(wb_rd)] <= wb_data;
      end
   end

   // Source reads: x0 and out-of-range indices return 0
   always_comb begin
      rs1_val = '0;
      if ((rs1_idx != 5'd0) && rs1_in_range) begin
         rs1_val = regs[AW'(rs1_idx)];
`ifdef DECODE_WB_BYPASS_EN
         if (wb_hit && (wb_rd == rs1_idx)) rs1_val = wb_data;
`endif
      end
   end

   always_comb begin
      rs2_val = '0;
      if ((rs2_idx != 5'd0) && rs2_in_range) begin
         rs2_val = regs[AW'(rs2_idx)];
`ifdef DECODE_WB_BYPASS_EN
         if (wb_hit && (wb_rd == rs2_idx)) rs2_val = wb_data;
`endif
      end
   end

   logic illegal;
   assign illegal = op_illegal ||
                    (use_rs1 && !rs1_in_range) ||
                    (use_rs2 && !rs2_in_range) ||
                    (use_rd  && !rd_in_range);

   // Early branch / jump resolution
   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] op_b;
   logic            br_taken;
   logic [XLEN-1:0] target_sum;
   logic            accept;

   assign op_a = fwd_rs1 ? exe_alu_result : rs1_val;
   assign op_b = fwd_rs2 ? exe_alu_result : rs2_val;

   always_comb begin
      br_taken = 1'b0;
      case (funct3)
         3'b000:  br_taken = (op_a == op_b);
         3'b001:  br_taken = (op_a != op_b);
         3'b100:  br_taken = ($signed(op_a) <  $signed(op_b));
         3'b101:  br_taken = ($signed(op_a) >= $signed(op_b));
         3'b110:  br_taken = (op_a <  op_b);
         3'b111:  br_taken = (op_a >= op_b);
         default: br_taken = 1'b0;
      endcase
   end

   // Reset holds the input side open while dropping everything presented
   assign in_ready      = rst || !out_valid || out_ready || flush_exe;
   assign accept        = in_valid && in_ready && !flush_exe && !rst;
   assign pc_src        = accept && (jal || jalr || (branch && br_taken));
   assign target_sum    = (jalr ? op_a : in_pc) + imm;
   assign branch_target = target_sum & ~(XLEN'(1));

   // Output stage: flush beats acceptance, acceptance beats drain
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid  <= 1'b0;
         out_rs1    <= '0;
         out_rs2    <= '0;
         out_imm    <= '0;
         out_pc     <= '0;
         out_pc_inc <= '0;
         out_a1     <= 5'd0;
         out_a2     <= 5'd0;
         out_rd     <= 5'd0;
         out_ctrl   <= 12'd0;
      end else if (flush_exe) begin
         out_valid <= 1'b0;
      end else if (accept) begin
         out_valid  <= 1'b1;
         out_rs1    <= rs1_val;
         out_rs2    <= rs2_val;
         out_imm    <= imm;
         out_pc     <= in_pc;
         out_pc_inc <= in_pc_inc;
         out_a1     <= rs1_idx;
         out_a2     <= rs2_idx;
         out_rd     <= rd_idx;
         out_ctrl   <= {reg_write, result_src, mem_store, mem_load,
                        alu_control, alu_src, illegal, 1'b0};
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_decode_unit.sv
// tb_decode_unit: directed self-checking bench for decode_unit.
// A second instance with NUM_REGS = 16 shares all inputs.

module tb_decode_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [31:0] in_instr;
   logic [31:0] in_pc;
   logic [31:0] in_pc_inc;
   logic        flush_exe;
   logic        fwd_rs1;
   logic        fwd_rs2;
   logic [31:0] exe_alu_result;
   logic        wb_wr_en;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        out_ready;

   logic        in_ready, pc_src, out_valid;
   logic [31:0] branch_target, out_rs1, out_rs2, out_imm, out_pc, out_pc_inc;
   logic [4:0]  rs1_d, rs2_d, out_a1, out_a2, out_rd;
   logic [11:0] out_ctrl;

   logic        s_in_ready, s_pc_src, s_out_valid;
   logic [31:0] s_branch_target, s_out_rs1, s_out_rs2, s_out_imm, s_out_pc, s_out_pc_inc;
   logic [4:0]  s_rs1_d, s_rs2_d, s_out_a1, s_out_a2, s_out_rd;
   logic [11:0] s_out_ctrl;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   decode_unit dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_pc(in_pc), .in_pc_inc(in_pc_inc),
      .flush_exe(flush_exe), .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2),
      .exe_alu_result(exe_alu_result), .wb_wr_en(wb_wr_en), .wb_rd(wb_rd),
      .wb_data(wb_data), .pc_src(pc_src), .branch_target(branch_target),
      .rs1_d(rs1_d), .rs2_d(rs2_d), .out_valid(out_valid), .out_ready(out_ready),
      .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm), .out_pc(out_pc),
      .out_pc_inc(out_pc_inc), .out_a1(out_a1), .out_a2(out_a2), .out_rd(out_rd),
      .out_ctrl(out_ctrl)
   );

   decode_unit #(.NUM_REGS(16)) dut16 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
      .in_instr(in_instr), .in_pc(in_pc), .in_pc_inc(in_pc_inc),
      .flush_exe(flush_exe), .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2),
      .exe_alu_result(exe_alu_result), .wb_wr_en(wb_wr_en), .wb_rd(wb_rd),
      .wb_data(wb_data), .pc_src(s_pc_src), .branch_target(s_branch_target),
      .rs1_d(s_rs1_d), .rs2_d(s_rs2_d), .out_valid(s_out_valid), .out_ready(out_ready),
      .out_rs1(s_out_rs1), .out_rs2(s_out_rs2), .out_imm(s_out_imm), .out_pc(s_out_pc),
      .out_pc_inc(s_out_pc_inc), .out_a1(s_out_a1), .out_a2(s_out_a2), .out_rd(s_out_rd),
      .out_ctrl(s_out_ctrl)
   );

   // Instruction encoders
   function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [4:0] rs2);
      return {7'd0, rs2, rs1, 3'b000, rd, 7'b0110011};
   endfunction

   function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [4:0] rd,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [11:0] imm12);
      return {imm12, rs1, f3, rd, op};
   endfunction

   function automatic logic [31:0] enc_s(input logic [11:0] imm12, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3);
      return {imm12[11:5], rs2, rs1, f3, imm12[4:0], 7'b0100011};
   endfunction

   function automatic logic [31:0] enc_b(input logic [12:0] off, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3);
      return {off[12], off[10:5], rs2, rs1, f3, off[4:1], off[11], 7'b1100011};
   endfunction

   function automatic logic [31:0] enc_j(input logic [20:0] off, input logic [4:0] rd);
      return {off[20], off[10:1], off[11], off[19:12], rd, 7'b1101111};
   endfunction

   // Present an instruction at the falling edge
   task automatic present(input logic [31:0] instr, input logic [31:0] pc);
      @(negedge clk);
      in_valid  = 1'b1;
      in_instr  = instr;
      in_pc     = pc;
      in_pc_inc = pc + 32'd4;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
   endtask

   task automatic wb_write(input logic [4:0] rd, input logic [31:0] data);
      @(negedge clk);
      in_valid = 1'b0;
      wb_wr_en = 1'b1;
      wb_rd    = rd;
      wb_data  = data;
      tick();
      wb_wr_en = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b1; in_instr = enc_j(21'd8, 5'd1);
      in_pc = 32'h40; in_pc_inc = 32'h44; out_ready = 1'b0;
      flush_exe = 1'b0; fwd_rs1 = 1'b0; fwd_rs2 = 1'b0; exe_alu_result = 32'd0;
      wb_wr_en = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
      tick();
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b exp 1", in_ready); end
      checks++; if (pc_src !== 1'b0) begin errors++; $display("FAIL rst_pc_src: got %b exp 0", pc_src); end
      tick();
      @(negedge clk);
      rst = 1'b0; in_valid = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b exp 0", out_valid); end
      checks++; if (out_ctrl !== 12'h000) begin errors++; $display("FAIL rst_out_ctrl: got %h exp 000", out_ctrl); end
      checks++; if ({out_rs1, out_rs2, out_imm, out_pc, out_pc_inc} !== 160'd0) begin
         errors++; $display("FAIL rst_out_data: got %h %h %h %h %h exp all 0", out_rs1, out_rs2, out_imm, out_pc, out_pc_inc); end
      checks++; if ({out_a1, out_a2, out_rd} !== 15'd0) begin
         errors++; $display("FAIL rst_out_idx: got %0d %0d %0d exp 0 0 0", out_a1, out_a2, out_rd); end
   endtask

   task automatic test_add();
      present(enc_r(5'd5, 5'd2, 5'd3), 32'h100);
      out_ready = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_pre_valid: got %b exp 0", out_valid); end
      checks++; if ({rs1_d, rs2_d} !== {5'd2, 5'd3}) begin errors++; $display("FAIL add_rs_d: got %0d %0d exp 2 3", rs1_d, rs2_d); end
      checks++; if (pc_src !== 1'b0) begin errors++; $display("FAIL add_pc_src: got %b exp 0", pc_src); end
      tick();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_valid: got %b exp 1", out_valid); end
      checks++; if (out_rs1 !== 32'h300) begin errors++; $display("FAIL add_rs1: got %h exp 300", out_rs1); end
      checks++; if (out_rs2 !== 32'h300) begin errors++; $display("FAIL add_rs2: got %h exp 300", out_rs2); end
      checks++; if ({out_a1, out_a2, out_rd} !== {5'd2, 5'd3, 5'd5}) begin
         errors++; $display("FAIL add_idx: got %0d %0d %0d exp 2 3 5", out_a1, out_a2, out_rd); end
      checks++; if (out_ctrl !== 12'h800) begin errors++; $display("FAIL add_ctrl: got %h exp 800", out_ctrl); end
      checks++; if ({out_pc, out_pc_inc} !== {32'h100, 32'h104}) begin
         errors++; $display("FAIL add_pc: got %h %h exp 100 104", out_pc, out_pc_inc); end
   endtask

   task automatic test_branch();
      wb_write(5'd6, 32'hFFFF_FFFF);
      wb_write(5'd7, 32'h0000_0001);
      // BLT signed: -1 < 1 taken
      present(enc_b(13'd16, 5'd7, 5'd6, 3'b100), 32'h100);
      #1;
      checks++; if (pc_src !== 1'b1) begin errors++; $display("FAIL blt_pc_src: got %b exp 1", pc_src); end
      checks++; if (branch_target !== 32'h110) begin errors++; $display("FAIL blt_target: got %h exp 110", branch_target); end
      tick();
      checks++; if (out_imm !== 32'h10) begin errors++; $display("FAIL blt_imm: got %h exp 10", out_imm); end
      checks++; if (out_ctrl !== 12'h040) begin errors++; $display("FAIL blt_ctrl: got %h exp 040", out_ctrl); end
      checks++; if ({out_rs1, out_rs2} !== {32'hFFFF_FFFF, 32'h1}) begin
         errors++; $display("FAIL blt_ops: got %h %h exp ffffffff 1", out_rs1, out_rs2); end
      // BLTU: 0xffffffff < 1 false
      present(enc_b(13'd16, 5'd7, 5'd6, 3'b110), 32'h100);
      #1;
      checks++; if (pc_src !== 1'b0) begin errors++; $display("FAIL bltu_pc_src: got %b exp 0", pc_src); end
      checks++; if (branch_target !== 32'h110) begin errors++; $display("FAIL bltu_target: got %h exp 110", branch_target); end
      // BGEU taken, negative offset
      present(enc_b(13'h1FF8, 5'd7, 5'd6, 3'b111), 32'h100);
      #1;
      checks++; if ({pc_src, branch_target} !== {1'b1, 32'hF8}) begin
         errors++; $display("FAIL bgeu_neg: got %b %h exp 1 f8", pc_src, branch_target); end
      // BEQ with rs2 forwarded equal to x6
      present(enc_b(13'd16, 5'd7, 5'd6, 3'b000), 32'h100);
      fwd_rs2 = 1'b1; exe_alu_result = 32'hFFFF_FFFF;
      #1;
      checks++; if (pc_src !== 1'b1) begin errors++; $display("FAIL beq_fwd: got %b exp 1", pc_src); end
      // Reserved funct3 010: never taken, illegal
      present(enc_b(13'd16, 5'd7, 5'd6, 3'b010), 32'h100);
      #1;
      checks++; if (pc_src !== 1'b0) begin errors++; $display("FAIL br010_pc_src: got %b exp 0", pc_src); end
      tick();
      checks++; if (out_ctrl !== 12'h042) begin errors++; $display("FAIL br010_ctrl: got %h exp 042", out_ctrl); end
      // JALR with forwarded base, bit 0 cleared
      present(enc_i(7'b1100111, 5'd1, 5'd6, 3'b000, 12'd4), 32'h100);
      fwd_rs2 = 1'b0; fwd_rs1 = 1'b1; exe_alu_result = 32'h2001;
      #1;
      checks++; if ({pc_src, branch_target} !== {1'b1, 32'h2004}) begin
         errors++; $display("FAIL jalr_fwd: got %b %h exp 1 2004", pc_src, branch_target); end
      tick();
      checks++; if (out_ctrl !== 12'hC04) begin errors++; $display("FAIL jalr_ctrl: got %h exp c04", out_ctrl); end
      fwd_rs1 = 1'b0;
   endtask

   task automatic test_stall();
      idle();
      present(enc_r(5'd5, 5'd2, 5'd3), 32'h180);
      out_ready = 1'b0;
      tick();
      present(enc_j(21'd8, 5'd1), 32'h200);
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if ({in_ready, pc_src} !== 2'b00) begin
            errors++; $display("FAIL stall_ready_pc_src[%0d]: got %b %b exp 0 0", i, in_ready, pc_src); end
         tick();
         checks++; if ({out_valid, out_rd, out_a1, out_pc} !== {1'b1, 5'd5, 5'd2, 32'h180}) begin
            errors++; $display("FAIL stall_hold[%0d]: got %b %0d %0d %h exp 1 5 2 180", i, out_valid, out_rd, out_a1, out_pc); end
         @(negedge clk);
      end
      out_ready = 1'b1;
      #1;
      checks++; if ({in_ready, pc_src} !== 2'b11) begin
         errors++; $display("FAIL stall_release: got %b %b exp 1 1", in_ready, pc_src); end
      checks++; if (branch_target !== 32'h208) begin errors++; $display("FAIL jal_target: got %h exp 208", branch_target); end
      tick();
      checks++; if ({out_valid, out_rd, out_imm, out_ctrl} !== {1'b1, 5'd1, 32'd8, 12'hC00}) begin
         errors++; $display("FAIL jal_payload: got %b %0d %h %h exp 1 1 8 c00", out_valid, out_rd, out_imm, out_ctrl); end
      checks++; if ({out_pc, out_pc_inc} !== {32'h200, 32'h204}) begin
         errors++; $display("FAIL jal_pc: got %h %h exp 200 204", out_pc, out_pc_inc); end
   endtask

   task automatic test_flush();
      // Flush with a taken JAL while EXE accepts
      present(enc_j(21'd8, 5'd1), 32'h300);
      flush_exe = 1'b1;
      #1;
      checks++; if ({in_ready, pc_src} !== 2'b10) begin
         errors++; $display("FAIL flush_jal: got %b %b exp 1 0", in_ready, pc_src); end
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b exp 0", out_valid); end
      // Flush overrides a stall
      present(enc_r(5'd5, 5'd2, 5'd3), 32'h400);
      flush_exe = 1'b0; out_ready = 1'b0;
      tick();
      present(enc_j(21'd8, 5'd1), 32'h404);
      flush_exe = 1'b1;
      #1;
      checks++; if ({in_ready, pc_src} !== 2'b10) begin
         errors++; $display("FAIL flush_stall: got %b %b exp 1 0", in_ready, pc_src); end
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_stall_valid: got %b exp 0", out_valid); end
      @(negedge clk);
      flush_exe = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
   endtask

   task automatic test_back_to_back();
      logic [31:0] t_instr [5];
      logic [31:0] t_imm   [5];
      logic [11:0] t_ctrl  [5];
      t_instr[0] = enc_i(7'b0010011, 5'd8, 5'd2, 3'b000, 12'hFFC);   // addi x8,x2,-4
      t_imm[0] = 32'hFFFF_FFFC; t_ctrl[0] = 12'h804;
      t_instr[1] = enc_i(7'b0010011, 5'd9, 5'd3, 3'b101, 12'h403);   // srai x9,x3,3
      t_imm[1] = 32'h3;         t_ctrl[1] = 12'h86C;
      t_instr[2] = {20'h80000, 5'd10, 7'b0110111};                  // lui x10,0x80000
      t_imm[2] = 32'h8000_0000; t_ctrl[2] = 12'h854;
      t_instr[3] = enc_i(7'b0000011, 5'd11, 5'd2, 3'b010, 12'd8);    // lw x11,8(x2)
      t_imm[3] = 32'h8;         t_ctrl[3] = 12'hA84;
      t_instr[4] = enc_s(12'hFF8, 5'd3, 5'd2, 3'b010);              // sw x3,-8(x2)
      t_imm[4] = 32'hFFFF_FFF8; t_ctrl[4] = 12'h104;
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         present(t_instr[i], 32'h1000 + 32'(i) * 32'd4);
         #1;
         checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d]: got %b exp 1", i, in_ready); end
         tick();
         checks++; if ({out_valid, out_imm, out_ctrl} !== {1'b1, t_imm[i], t_ctrl[i]}) begin
            errors++; $display("FAIL b2b_payload[%0d]: got %b %h %h exp 1 %h %h", i, out_valid, out_imm, out_ctrl, t_imm[i], t_ctrl[i]); end
      end
      checks++; if (out_rs2 !== 32'h300) begin errors++; $display("FAIL b2b_sw_rs2: got %h exp 300", out_rs2); end
      @(negedge clk);
      in_valid = 1'b0;
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b exp 0", out_valid); end
   endtask

   task automatic test_wb_bypass();
      logic [31:0] exp_rs1;
`ifdef DECODE_WB_BYPASS_EN
      exp_rs1 = 32'h1234;
`else
      exp_rs1 = 32'h55;
`endif
      wb_write(5'd9, 32'h55);
      present(enc_r(5'd12, 5'd9, 5'd0), 32'h500);
      wb_wr_en = 1'b1; wb_rd = 5'd9; wb_data = 32'h1234;
      tick();
      checks++; if (out_rs1 !== exp_rs1) begin errors++; $display("FAIL wb_same_cycle: got %h exp %h", out_rs1, exp_rs1); end
      present(enc_r(5'd12, 5'd9, 5'd0), 32'h504);
      wb_wr_en = 1'b0;
      tick();
      checks++; if (out_rs1 !== 32'h1234) begin errors++; $display("FAIL wb_next_cycle: got %h exp 1234", out_rs1); end
   endtask

   task automatic test_small_regfile();
      present(enc_r(5'd20, 5'd2, 5'd2), 32'h600);
      tick();
      checks++; if ({s_out_ctrl, s_out_rs1, s_out_rd} !== {12'h802, 32'h300, 5'd20}) begin
         errors++; $display("FAIL r16_rd_illegal: got %h %h %0d exp 802 300 20", s_out_ctrl, s_out_rs1, s_out_rd); end
      checks++; if (out_ctrl !== 12'h800) begin errors++; $display("FAIL r32_rd_legal: got %h exp 800", out_ctrl); end
      wb_write(5'd20, 32'hDEAD);
      present(enc_r(5'd5, 5'd4, 5'd20), 32'h604);
      tick();
      checks++; if ({s_out_rs1, s_out_rs2, s_out_ctrl} !== {32'h0, 32'h0, 12'h802}) begin
         errors++; $display("FAIL r16_wb_ignored: got %h %h %h exp 0 0 802", s_out_rs1, s_out_rs2, s_out_ctrl); end
      checks++; if ({out_rs2, out_ctrl} !== {32'hDEAD, 12'h800}) begin
         errors++; $display("FAIL r32_wb_x20: got %h %h exp dead 800", out_rs2, out_ctrl); end
   endtask

   task automatic test_reset_mid_stall();
      idle();
      present(enc_r(5'd5, 5'd6, 5'd7), 32'h700);
      out_ready = 1'b0;
      tick();
      checks++; if ({out_valid, out_rs1} !== {1'b1, 32'hFFFF_FFFF}) begin
         errors++; $display("FAIL mid_stall_setup: got %b %h exp 1 ffffffff", out_valid, out_rs1); end
      @(negedge clk);
      rst = 1'b1; in_valid = 1'b0;
      tick();
      checks++; if ({out_valid, out_a1, out_rs1, in_ready} !== {1'b0, 5'd0, 32'd0, 1'b1}) begin
         errors++; $display("FAIL mid_stall_reset: got %b %0d %h %b exp 0 0 0 1", out_valid, out_a1, out_rs1, in_ready); end
      @(negedge clk);
      rst = 1'b0; out_ready = 1'b1;
      present(enc_r(5'd5, 5'd6, 5'd7), 32'h704);
      tick();
      checks++; if ({out_rs1, out_rs2} !== 64'd0) begin
         errors++; $display("FAIL regs_cleared: got %h %h exp 0 0", out_rs1, out_rs2); end
      present(enc_r(5'd5, 5'd2, 5'd3), 32'h708);
      tick();
      checks++; if ({out_rs1, out_rs2} !== {32'h300, 32'h300}) begin
         errors++; $display("FAIL regs_reinit: got %h %h exp 300 300", out_rs1, out_rs2); end
   endtask

   initial begin
      test_reset();
      test_add();
      test_branch();
      test_stall();
      test_flush();
      test_back_to_back();
      test_wb_bypass();
      test_small_regfile();
      test_reset_mid_stall();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
